decode_e_pipe_reg: RTL and testbench

//   Y86-64 pipeline decode stage with its D->E pipeline register.
//   - Decodes srcA/srcB from the D-stage instruction fields.
//   - Reads a 15 x 64-bit register file; the W stage writes it back.
//   - Latches the decoded bundle into the E register.

---
 rtl/y86_pkg.sv | 68 ++++++
 rtl/regfile_pipe.sv | 62 ++++++
 rtl/decode_e_pipe_reg.sv | 93 +++++++++
 tb/tb_decode_e_pipe_reg.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: widths, icodes, register ids, E-stage bundle.
// Pure definitions; no latency and no flow control of its own.
package y86_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 15;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      icode;
    logic [3:0]      ifunc;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] vala;
    logic [XLEN-1:0] valb;
    logic [3:0]      srca;
    logic [3:0]      srcb;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    pc:    '0,
    icode: I_NOP,
    ifunc: 4'h0,
    valc:  '0,
    vala:  '0,
    valb:  '0,
    srca:  RNONE,
    srcb:  RNONE
  };

  function automatic logic [3:0] decode_src_a(input logic [3:0] icode, input logic [3:0] ra);
    logic [3:0] src;
    case (icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ:                 src = ra;
      I_RET, I_POPQ:                                      src = RRSP;
      I_HALT, I_NOP, I_IRMOVQ, I_MRMOVQ, I_JXX, I_CALL:   src = RNONE;
      default:                                            src = RNONE;
    endcase
    return src;
  endfunction

  function automatic logic [3:0] decode_src_b(input logic [3:0] icode, input logic [3:0] rb);
    logic [3:0] src;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:                          src = rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:                     src = RRSP;
      I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_JXX:           src = RNONE;
      default:                                            src = RNONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/regfile_pipe.sv
// 15 x XLEN register file, two combinational read ports, two write ports (M beats E), sync clear.
// Reads zero latency (old value, or W bypass under DECODE_WB_BYPASS_EN); writes land on the edge; no backpressure.
module regfile_pipe
  import y86_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [3:0]      rd_a_id_i,
  output logic [XLEN-1:0] rd_a_dat_o,
  input  logic [3:0]      rd_b_id_i,
  output logic [XLEN-1:0] rd_b_dat_o,
  input  logic [3:0]      wr_e_id_i,
  input  logic [XLEN-1:0] wr_e_dat_i,
  input  logic [3:0]      wr_m_id_i,
  input  logic [XLEN-1:0] wr_m_dat_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [3:0]      rd_id  [2];
  logic [XLEN-1:0] rd_dat [2];

  // E first, then M, so a shared destination ends up holding valM.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_e_id_i == 4'(i)) regs_d[i] = wr_e_dat_i;
      if (wr_m_id_i == 4'(i)) regs_d[i] = wr_m_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd_id[0] = rd_a_id_i;
  assign rd_id[1] = rd_b_id_i;

  // RNONE matches no storage slot, so it reads as zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dat[p] = '0;
      for (int i = 0; i < NREGS; i++) begin
        if (rd_id[p] == 4'(i)) rd_dat[p] = regs_q[i];
      end
`ifdef DECODE_WB_BYPASS_EN
      if (rd_id[p] != RNONE) begin
        if (rd_id[p] == wr_e_id_i) rd_dat[p] = wr_e_dat_i;
        if (rd_id[p] == wr_m_id_i) rd_dat[p] = wr_m_dat_i;
      end
`endif
    end
  end

  assign rd_a_dat_o = rd_dat[0];
  assign rd_b_dat_o = rd_dat[1];

endmodule

// File: rtl/decode_e_pipe_reg.sv
// Y86-64 decode (srcA/srcB + regfile read) feeding the D->E register; DECODE_WB_BYPASS_EN enables W bypass.
// d_* outputs zero latency, E_* one cycle; E_stall_i holds (beats E_bubble_i), E_bubble_i loads a NOP.
module decode_e_pipe_reg
  import y86_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] D_pc_i,
  input  logic [3:0]      D_icode_i,
  input  logic [3:0]      D_ifunc_i,
  input  logic [3:0]      D_rA_i,
  input  logic [3:0]      D_rB_i,
  input  logic [XLEN-1:0] D_valC_i,
  input  logic [3:0]      W_dstE_i,
  input  logic [XLEN-1:0] W_valE_i,
  input  logic [3:0]      W_dstM_i,
  input  logic [XLEN-1:0] W_valM_i,
  input  logic            E_stall_i,
  input  logic            E_bubble_i,
  output logic [3:0]      d_srcA_o,
  output logic [3:0]      d_srcB_o,
  output logic [XLEN-1:0] d_valA_o,
  output logic [XLEN-1:0] d_valB_o,
  output logic [XLEN-1:0] E_pc_o,
  output logic [3:0]      E_icode_o,
  output logic [3:0]      E_ifunc_o,
  output logic [XLEN-1:0] E_valC_o,
  output logic [XLEN-1:0] E_valA_o,
  output logic [XLEN-1:0] E_valB_o,
  output logic [3:0]      E_srcA_o,
  output logic [3:0]      E_srcB_o
);

  logic [3:0]      srca;
  logic [3:0]      srcb;
  logic [XLEN-1:0] vala;
  logic [XLEN-1:0] valb;
  e_reg_t          e_d;
  e_reg_t          e_q;

  assign srca = decode_src_a(D_icode_i, D_rA_i);
  assign srcb = decode_src_b(D_icode_i, D_rB_i);

  regfile_pipe u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rd_a_id_i  (srca),
    .rd_a_dat_o (vala),
    .rd_b_id_i  (srcb),
    .rd_b_dat_o (valb),
    .wr_e_id_i  (W_dstE_i),
    .wr_e_dat_i (W_valE_i),
    .wr_m_id_i  (W_dstM_i),
    .wr_m_dat_i (W_valM_i)
  );

  always_comb begin
    e_d = e_q;
    if (E_stall_i) begin
      e_d = e_q;
    end else if (E_bubble_i) begin
      e_d = E_BUBBLE;
    end else begin
      e_d.pc    = D_pc_i;
      e_d.icode = D_icode_i;
      e_d.ifunc = D_ifunc_i;
      e_d.valc  = D_valC_i;
      e_d.vala  = vala;
      e_d.valb  = valb;
      e_d.srca  = srca;
      e_d.srcb  = srcb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) e_q <= E_BUBBLE;
    else          e_q <= e_d;
  end

  assign d_srcA_o  = srca;
  assign d_srcB_o  = srcb;
  assign d_valA_o  = vala;
  assign d_valB_o  = valb;
  assign E_pc_o    = e_q.pc;
  assign E_icode_o = e_q.icode;
  assign E_ifunc_o = e_q.ifunc;
  assign E_valC_o  = e_q.valc;
  assign E_valA_o  = e_q.vala;
  assign E_valB_o  = e_q.valb;
  assign E_srcA_o  = e_q.srca;
  assign E_srcB_o  = e_q.srcb;

endmodule

// File: tb/tb_decode_e_pipe_reg.sv
// Directed bench for decode_e_pipe_reg: decode table, regfile read/write, E register control.
module tb_decode_e_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [63:0] D_pc_i, D_valC_i, W_valE_i, W_valM_i;
  logic [3:0]  D_icode_i, D_ifunc_i, D_rA_i, D_rB_i, W_dstE_i, W_dstM_i;
  logic        E_stall_i, E_bubble_i;
  logic [3:0]  d_srcA_o, d_srcB_o, E_icode_o, E_ifunc_o, E_srcA_o, E_srcB_o;
  logic [63:0] d_valA_o, d_valB_o, E_pc_o, E_valC_o, E_valA_o, E_valB_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  decode_e_pipe_reg dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .D_pc_i(D_pc_i), .D_icode_i(D_icode_i), .D_ifunc_i(D_ifunc_i),
    .D_rA_i(D_rA_i), .D_rB_i(D_rB_i), .D_valC_i(D_valC_i),
    .W_dstE_i(W_dstE_i), .W_valE_i(W_valE_i), .W_dstM_i(W_dstM_i), .W_valM_i(W_valM_i),
    .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i),
    .d_srcA_o(d_srcA_o), .d_srcB_o(d_srcB_o), .d_valA_o(d_valA_o), .d_valB_o(d_valB_o),
    .E_pc_o(E_pc_o), .E_icode_o(E_icode_o), .E_ifunc_o(E_ifunc_o), .E_valC_o(E_valC_o),
    .E_valA_o(E_valA_o), .E_valB_o(E_valB_o), .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] pc, input logic [63:0] valc);
    D_icode_i = icode; D_ifunc_i = 4'h0; D_rA_i = ra; D_rB_i = rb;
    D_pc_i = pc; D_valC_i = valc;
    #1;
  endtask

  task automatic drive_w(input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    W_dstE_i = de; W_valE_i = ve; W_dstM_i = dm; W_valM_i = vm;
    #1;
  endtask

  // icode, rA, rB, expected srcA, expected srcB
  logic [3:0] dec_tab [8][5] = '{
    '{4'h2, 4'h1, 4'h3, 4'h1, 4'hF},
    '{4'h4, 4'h5, 4'h6, 4'h5, 4'h6},
    '{4'h5, 4'h5, 4'h6, 4'hF, 4'h6},
    '{4'h7, 4'h5, 4'h6, 4'hF, 4'hF},
    '{4'h8, 4'h5, 4'h6, 4'hF, 4'h4},
    '{4'h9, 4'h5, 4'h6, 4'h4, 4'h4},
    '{4'hC, 4'h5, 4'h6, 4'hF, 4'hF},
    '{4'h0, 4'h5, 4'h6, 4'hF, 4'hF}
  };

  initial begin
    rst_n_i = 1'b0; E_stall_i = 1'b0; E_bubble_i = 1'b0;
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    drive_d(4'h6, 4'h2, 4'h3, 64'h55, 64'h77);
    step();
    chk("rst_icode", 64'(E_icode_o), 64'h1);
    chk("rst_srca",  64'(E_srcA_o),  64'hF);
    chk("rst_srcb",  64'(E_srcB_o),  64'hF);
    chk("rst_pc",    E_pc_o,         64'h0);
    chk("rst_vala",  E_valA_o,       64'h0);
    rst_n_i = 1'b1;

    drive_d(4'h3, 4'hF, 4'h0, 64'h0, 64'h0);
    chk("irm_d_srca", 64'(d_srcA_o), 64'hF);
    chk("irm_d_srcb", 64'(d_srcB_o), 64'hF);
    chk("irm_d_vala", d_valA_o, 64'h0);
    chk("irm_d_valb", d_valB_o, 64'h0);
    step();
    chk("irm_e_icode", 64'(E_icode_o), 64'h3);
    chk("irm_e_srca",  64'(E_srcA_o),  64'hF);
    chk("irm_e_srcb",  64'(E_srcB_o),  64'hF);
    chk("irm_e_valc",  E_valC_o, 64'h0);
    chk("irm_e_pc",    E_pc_o,   64'h0);

    drive_w(4'h2, 64'h5, 4'hF, 64'h0);
    step();
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    drive_d(4'h6, 4'h2, 4'h3, 64'h10, 64'h0);
    chk("opq_d_srca", 64'(d_srcA_o), 64'h2);
    chk("opq_d_vala", d_valA_o, 64'h5);
    chk("opq_d_srcb", 64'(d_srcB_o), 64'h3);
    chk("opq_d_valb", d_valB_o, 64'h0);
    step();
    chk("opq_e_vala",  E_valA_o, 64'h5);
    chk("opq_e_icode", 64'(E_icode_o), 64'h6);
    chk("opq_e_pc",    E_pc_o, 64'h10);

    drive_w(4'hF, 64'h0, 4'h4, 64'h100);
    step();
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    drive_d(4'hA, 4'h2, 4'hF, 64'h18, 64'h0);
    chk("push_srca", 64'(d_srcA_o), 64'h2);
    chk("push_srcb", 64'(d_srcB_o), 64'h4);
    chk("push_valb", d_valB_o, 64'h100);
    chk("push_vala", d_valA_o, 64'h5);
    drive_d(4'hB, 4'h3, 4'hF, 64'h20, 64'h0);
    chk("pop_srca", 64'(d_srcA_o), 64'h4);
    chk("pop_srcb", 64'(d_srcB_o), 64'h4);
    chk("pop_vala", d_valA_o, 64'h100);

    for (int i = 0; i < 8; i++) begin
      drive_d(dec_tab[i][0], dec_tab[i][1], dec_tab[i][2], 64'h0, 64'h0);
      chk($sformatf("dec_srca_%0h", dec_tab[i][0]), 64'(d_srcA_o), 64'(dec_tab[i][3]));
      chk($sformatf("dec_srcb_%0h", dec_tab[i][0]), 64'(d_srcB_o), 64'(dec_tab[i][4]));
    end

    drive_d(4'hB, 4'h3, 4'hF, 64'h20, 64'h0);
    step();
    E_stall_i = 1'b1;
    drive_d(4'h6, 4'h2, 4'h3, 64'h99, 64'hABC);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_icode_%0d", i), 64'(E_icode_o), 64'hB);
      chk($sformatf("stall_vala_%0d", i), E_valA_o, 64'h100);
      chk($sformatf("stall_pc_%0d", i), E_pc_o, 64'h20);
    end
    E_bubble_i = 1'b1;
    step();
    chk("stallbub_icode", 64'(E_icode_o), 64'hB);
    chk("stallbub_srca",  64'(E_srcA_o),  64'h4);
    E_stall_i = 1'b0;
    step();
    chk("bub_icode", 64'(E_icode_o), 64'h1);
    chk("bub_srca",  64'(E_srcA_o),  64'hF);
    chk("bub_srcb",  64'(E_srcB_o),  64'hF);
    chk("bub_pc",    E_pc_o,   64'h0);
    chk("bub_vala",  E_valA_o, 64'h0);
    chk("bub_valc",  E_valC_o, 64'h0);
    E_bubble_i = 1'b0;

    drive_d(4'h6, 4'h3, 4'h3, 64'h30, 64'h0);
    drive_w(4'h3, 64'h7, 4'hF, 64'h0);
`ifdef DECODE_WB_BYPASS_EN
    chk("rdw_vala", d_valA_o, 64'h7);
`else
    chk("rdw_vala", d_valA_o, 64'h0);
`endif
    step();
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    chk("rdw_after", d_valA_o, 64'h7);
    drive_w(4'h3, 64'h1, 4'h3, 64'h2);
    step();
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    chk("dual_wr_m_wins", d_valA_o, 64'h2);

    drive_d(4'h6, 4'h2, 4'h3, 64'h40, 64'h0);
    drive_w(4'h2, 64'h9, 4'hF, 64'h0);
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    drive_w(4'hF, 64'h0, 4'hF, 64'h0);
    chk("midrst_r2",    d_valA_o, 64'h0);
    chk("midrst_r3",    d_valB_o, 64'h0);
    chk("midrst_icode", 64'(E_icode_o), 64'h1);
    chk("midrst_pc",    E_pc_o, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
